mul32_pipe: RTL and testbench
=============================

# mul32_pipe

Pipelined 32×32→64-bit multiplier with a per-operation signed/unsigned select, built as a Dadda reduction tree followed by a final carry-propagate adder. It accepts one operand pair per clock and streams out one 64-bit product per clock after a fixed latency. It is the arithmetic core behind the LFSR-driven hardware exerciser: two 32-bit pseudo-random sources feed `a` and `b`, and `mode` toggles each cycle.

## Interface
Parameters: none; widths are fixed at 32-bit operands and a 64-bit product.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low (0 = reset).
- `a`  in  32  multiplicand.
- `b`  in  32  multiplier.
- `mode`  in  1  operation select: 0 = unsigned × unsigned, 1 = signed × signed (two's complement).
- `hi`  out  32  product bits [63:32].
- `lo`  out  32  product bits [31:0].

## Operation
- Product P = a × b, interpreted according to `mode`, and always exact in 64 bits. Overflow cannot occur.
- mode=0: both operands are zero-extended.
- mode=1: both operands are sign-extended. Signed handling uses Baugh-Wooley style partial-product inversion plus correction constants, so no separate negation pass is needed.
- Stage 1: register `a`, `b` and `mode`.
- Stage 2: generate 32 partial-product rows, reduce them with a Dadda tree (3:2 and 2:2 counters) down to two 64-bit rows, then register the two rows.
- Stage 3: add the two rows with a 64-bit carry-propagate adder and register the result into `{hi, lo}`.
- `mode` travels down the pipeline with its operands. Each in-flight operation keeps the mode it was sampled with, so changing `mode` every cycle is legal.
- There is no handshake and no stall. A new operation is accepted every cycle, and the pipeline always advances.

## Timing
- Inputs are sampled on rising edge n. `{hi, lo}` holds the corresponding product after rising edge n+2, i.e. latency is 3 register stages.
- Throughput: one product per cycle.
- `hi` and `lo` change only on rising edges while `rst`=1. They are glitch-free register outputs.
- Reset (`rst`=0): asynchronously clears all pipeline registers, including the staged `mode`. `hi` and `lo` go to 0 immediately and stay 0 while reset is held.
- Reset release: the first edge with `rst`=1 samples inputs as normal. Its product appears 2 edges later; `hi`/`lo` read 0 until then.
- Reset mid-stream: all in-flight products are discarded and never appear on the outputs.
- Inputs must be stable around each rising edge. Changing them between edges has no effect.

## Configuration
- `MUL32_PIPE_SIGNED_EN` defined: `mode` works as specified above (signed and unsigned).
- `MUL32_PIPE_SIGNED_EN` undefined:
  - The signed correction logic and the mode pipeline register are omitted.
  - `mode` is ignored and every operation is unsigned.
  - Latency and ports are unchanged.

## Test plan
- Reset: hold `rst`=0 with a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0x00000000, lo=0x00000000 for the whole reset period. After release, outputs stay 0 for 2 edges.
- Unsigned max: a=0xFFFFFFFF, b=0xFFFFFFFF, mode=0 → hi=0xFFFFFFFE, lo=0x00000001, 3 edges after sampling.
- Signed −1×−1: same operands, mode=1 → hi=0x00000000, lo=0x00000001.
- Sign extension: a=0xDEADBEEF, b=0x00000001:
  - mode=0 → hi=0x00000000, lo=0xDEADBEEF.
  - mode=1 → hi=0xFFFFFFFF, lo=0xDEADBEEF.
  - a=0x80000000, b=0x80000000, mode=1 → hi=0x40000000, lo=0x00000000.
- Streaming: drive new pseudo-random operands every cycle (a: LFSR seed 0x00000001, mask 0x80200003; b: seed 0xDEADBEEF, mask 0x80000063) with `mode` alternating each cycle. Compare every output against a behavioural model delayed 3 cycles → zero mismatches over 4096 cycles.
- Reset mid-stream: assert `rst` asynchronously between edges during streaming → outputs go to 0 at once. After release, the first non-zero result corresponds to the first operands sampled after release.

Source files
------------

// File: rtl/mul32_pipe.sv
// mul32_pipe: 3-stage pipelined 32x32->64 multiplier.
// Stage 1 registers operands, stage 2 builds partial products and reduces them
// with a Dadda tree to two rows, stage 3 adds the rows into {hi, lo}.
// Optional feature macro: MUL32_PIPE_SIGNED_EN. When defined, mode=1 selects
// signed x signed using Baugh-Wooley inversion and correction constants; when
// undefined, mode is ignored and every product is unsigned.
module mul32_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mode,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef struct packed {
        logic [63:0] r0;
        logic [63:0] r1;
    } rows_t;

    // Dadda height targets, largest first (max column height is 32).
    function automatic logic [6:0] dadda_target(input logic [2:0] stage);
        logic [6:0] t;
        case (stage)
            3'd0:    t = 7'd28;
            3'd1:    t = 7'd19;
            3'd2:    t = 7'd13;
            3'd3:    t = 7'd9;
            3'd4:    t = 7'd6;
            3'd5:    t = 7'd4;
            3'd6:    t = 7'd3;
            default: t = 7'd2;
        endcase
        return t;
    endfunction

    // Builds the partial-product columns and compresses them to two rows.
    // Columns are walked LSB first so carries already dropped into a column by
    // its lower neighbour count toward that column's height target.
    function automatic rows_t dadda_rows(
        input logic [31:0] op_a,
        input logic [31:0] op_b
`ifdef MUL32_PIPE_SIGNED_EN
        , input logic sgn
`endif
    );
        logic [32:0] cur_bits [64];
        logic [32:0] nxt_bits [64];
        logic [6:0]  cur_cnt  [64];
        logic [6:0]  nxt_cnt  [64];
        logic [6:0]  idx, rem, eff, tgt;
        logic [5:0]  col, col1, i0, i1, i2;
        logic        pp, x0, x1, x2, s_bit, c_bit;
        rows_t       rows;

        idx   = '0;
        rem   = '0;
        eff   = '0;
        tgt   = '0;
        col   = '0;
        col1  = '0;
        i0    = '0;
        i1    = '0;
        i2    = '0;
        pp    = 1'b0;
        x0    = 1'b0;
        x1    = 1'b0;
        x2    = 1'b0;
        s_bit = 1'b0;
        c_bit = 1'b0;
        rows  = '0;

        for (int unsigned c = 0; c < 64; c++) begin
            cur_bits[6'(c)] = '0;
            nxt_bits[6'(c)] = '0;
            cur_cnt[6'(c)]  = '0;
            nxt_cnt[6'(c)]  = '0;
        end

        for (int unsigned i = 0; i < 32; i++) begin
            for (int unsigned j = 0; j < 32; j++) begin
                pp = op_a[5'(j)] & op_b[5'(i)];
`ifdef MUL32_PIPE_SIGNED_EN
                // Terms pairing one sign bit with one magnitude bit are inverted.
                if (sgn && ((i == 31) != (j == 31)))
                    pp = ~pp;
`endif
                col = 6'(i + j);
                cur_bits[col][cur_cnt[col][5:0]] = pp;
                cur_cnt[col] = cur_cnt[col] + 7'd1;
            end
        end

`ifdef MUL32_PIPE_SIGNED_EN
        // Baugh-Wooley correction constants: +2^32 and +2^63.
        if (sgn) begin
            cur_bits[32][cur_cnt[32][5:0]] = 1'b1;
            cur_cnt[32] = cur_cnt[32] + 7'd1;
            cur_bits[63][cur_cnt[63][5:0]] = 1'b1;
            cur_cnt[63] = cur_cnt[63] + 7'd1;
        end
`endif

        for (int unsigned s = 0; s < 8; s++) begin
            tgt = dadda_target(3'(s));
            for (int unsigned c = 0; c < 64; c++) begin
                nxt_bits[6'(c)] = '0;
                nxt_cnt[6'(c)]  = '0;
            end
            for (int unsigned c = 0; c < 64; c++) begin
                col  = 6'(c);
                col1 = col + 6'd1;
                idx  = '0;
                for (int unsigned k = 0; k < 16; k++) begin
                    rem = cur_cnt[col] - idx;
                    eff = rem + nxt_cnt[col];
                    if (eff > tgt && rem >= 7'd2) begin
                        i0 = idx[5:0];
                        i1 = i0 + 6'd1;
                        x0 = cur_bits[col][i0];
                        x1 = cur_bits[col][i1];
                        if (eff == tgt + 7'd1 || rem == 7'd2) begin
                            s_bit = x0 ^ x1;
                            c_bit = x0 & x1;
                            idx   = idx + 7'd2;
                        end else begin
                            i2    = i0 + 6'd2;
                            x2    = cur_bits[col][i2];
                            s_bit = x0 ^ x1 ^ x2;
                            c_bit = (x0 & x1) | (x0 & x2) | (x1 & x2);
                            idx   = idx + 7'd3;
                        end
                        nxt_bits[col][nxt_cnt[col][5:0]] = s_bit;
                        nxt_cnt[col] = nxt_cnt[col] + 7'd1;
                        // Carries out of bit 63 fall outside the 64-bit product.
                        if (c < 63) begin
                            nxt_bits[col1][nxt_cnt[col1][5:0]] = c_bit;
                            nxt_cnt[col1] = nxt_cnt[col1] + 7'd1;
                        end
                    end
                end
                for (int unsigned k = 0; k < 33; k++) begin
                    if (idx < cur_cnt[col]) begin
                        nxt_bits[col][nxt_cnt[col][5:0]] = cur_bits[col][idx[5:0]];
                        nxt_cnt[col] = nxt_cnt[col] + 7'd1;
                        idx = idx + 7'd1;
                    end
                end
            end
            for (int unsigned c = 0; c < 64; c++) begin
                cur_bits[6'(c)] = nxt_bits[6'(c)];
                cur_cnt[6'(c)]  = nxt_cnt[6'(c)];
            end
        end

        for (int unsigned c = 0; c < 64; c++) begin
            col = 6'(c);
            rows.r0[col] = cur_bits[col][0];
            rows.r1[col] = cur_bits[col][1];
        end
        return rows;
    endfunction

    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    rows_t       rows_q, rows_d;
    logic [63:0] prod_q, prod_d;

`ifdef MUL32_PIPE_SIGNED_EN
    logic        mode_q, mode_d;

    // Stage 1 next state: capture operands together with their mode.
    always_comb begin
        a_d    = a;
        b_d    = b;
        mode_d = mode;
    end

    // Stage 2 next state: partial products reduced to two rows.
    always_comb begin
        rows_d = dadda_rows(a_q, b_q, mode_q);
    end
`else
    logic        unused_mode;
    assign unused_mode = mode;

    // Stage 1 next state: capture operands.
    always_comb begin
        a_d = a;
        b_d = b;
    end

    // Stage 2 next state: partial products reduced to two rows.
    always_comb begin
        rows_d = dadda_rows(a_q, b_q);
    end
`endif

    // Stage 3 next state: carry-propagate add of the two reduced rows.
    always_comb begin
        prod_d = rows_q.r0 + rows_q.r1;
    end

    // Pipeline registers; reset clears everything so in-flight work is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
`ifdef MUL32_PIPE_SIGNED_EN
            mode_q <= 1'b0;
`endif
            rows_q <= '0;
            prod_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
`ifdef MUL32_PIPE_SIGNED_EN
            mode_q <= mode_d;
`endif
            rows_q <= rows_d;
            prod_q <= prod_d;
        end
    end

    assign hi = prod_q[63:32];
    assign lo = prod_q[31:0];

endmodule

// File: tb/tb_mul32_pipe.sv
// Testbench for mul32_pipe: directed table, reset sequences and LFSR streaming.
// Expected values for mode=1 follow MUL32_PIPE_SIGNED_EN (unsigned when undefined).
module tb_mul32_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        mode;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

`ifdef MUL32_PIPE_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic        vmode;
        logic [63:0] exp_s;
        logic [63:0] exp_u;
    } vec_t;

    vec_t        vecs [12];
    logic [63:0] expq [$];

    mul32_pipe dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .mode (mode),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mm);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (SIGNED_EN && mm) begin
            sa = {{32{ma[31]}}, ma};
            sb = {{32{mb[31]}}, mb};
            return 64'(sa * sb);
        end
        return {32'd0, ma} * {32'd0, mb};
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] x, input logic [31:0] m);
        return x[0] ? ((x >> 1) ^ m) : (x >> 1);
    endfunction

    task automatic check(input string name, input logic [63:0] exp);
        checks++;
        if ({hi, lo} !== exp) begin
            errors++;
            $display("FAIL %s: got %h_%h expected %h_%h", name, hi, lo, exp[63:32], exp[31:0]);
        end
    endtask

    initial begin
        logic [31:0] la;
        logic [31:0] lb;
        logic        lm;
        logic [63:0] e;

        checks = 0;
        errors = 0;

        vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 64'hFFFFFFFE_00000001};
        vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001, 64'hFFFFFFFE_00000001};
        vecs[2]  = '{32'hDEADBEEF, 32'h00000001, 1'b0, 64'h00000000_DEADBEEF, 64'h00000000_DEADBEEF};
        vecs[3]  = '{32'hDEADBEEF, 32'h00000001, 1'b1, 64'hFFFFFFFF_DEADBEEF, 64'h00000000_DEADBEEF};
        vecs[4]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 64'h40000000_00000000};
        vecs[5]  = '{32'h00000000, 32'h12345678, 1'b0, 64'h00000000_00000000, 64'h00000000_00000000};
        vecs[6]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF_00000001, 64'h3FFFFFFF_00000001};
        vecs[7]  = '{32'hFFFFFFFF, 32'h00000002, 1'b1, 64'hFFFFFFFF_FFFFFFFE, 64'h00000001_FFFFFFFE};
        vecs[8]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC0000000_80000000, 64'h3FFFFFFF_80000000};
        vecs[9]  = '{32'h00010000, 32'h00010000, 1'b0, 64'h00000001_00000000, 64'h00000001_00000000};
        vecs[10] = '{32'h0000FFFF, 32'h0000FFFF, 1'b1, 64'h00000000_FFFE0001, 64'h00000000_FFFE0001};
        vecs[11] = '{32'hFFFFFFFF, 32'h80000000, 1'b1, 64'h00000000_80000000, 64'h7FFFFFFF_80000000};

        // Reset held with all-ones operands: outputs stay zero.
        rst  = 1'b0;
        a    = 32'hFFFFFFFF;
        b    = 32'hFFFFFFFF;
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("reset_held", 64'd0);
        end

        // Release: two zero edges, then the first sampled product.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1; check("release_edge1", 64'd0);
        @(posedge clk); #1; check("release_edge2", 64'd0);
        @(posedge clk); #1; check("release_edge3", 64'hFFFFFFFE_00000001);

        // Directed table, one vector per cycle (mode changes between vectors).
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k < 12) begin
                a    = vecs[k].va;
                b    = vecs[k].vb;
                mode = vecs[k].vmode;
            end
            @(posedge clk);
            #1;
            if (k >= 2) begin
                e = (SIGNED_EN && vecs[k-2].vmode) ? vecs[k-2].exp_s : vecs[k-2].exp_u;
                check($sformatf("vec%0d", k - 2), e);
            end
        end

        // Streaming with LFSR operands and alternating mode.
        la = 32'h00000001;
        lb = 32'hDEADBEEF;
        lm = 1'b0;
        expq.delete();
        for (int k = 0; k < 4098; k++) begin
            @(negedge clk);
            if (k < 4096) begin
                a    = la;
                b    = lb;
                mode = lm;
                expq.push_back(model(la, lb, lm));
                la = lfsr_step(la, 32'h80200003);
                lb = lfsr_step(lb, 32'h80000063);
                lm = ~lm;
            end
            @(posedge clk);
            #1;
            if (k >= 2)
                check("stream", expq.pop_front());
        end

        // Mid-stream reset: fill the pipe, then assert reset between edges.
        expq.delete();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            a    = la;
            b    = lb;
            mode = lm;
            expq.push_back(model(la, lb, lm));
            la = lfsr_step(la, 32'h80200003);
            lb = lfsr_step(lb, 32'h80000063);
            lm = ~lm;
            @(posedge clk);
            #1;
            if (k >= 2)
                check("prereset_stream", expq.pop_front());
        end
        #2;
        rst = 1'b0;
        #1;
        check("midreset_async", 64'd0);
        @(posedge clk); #1; check("midreset_held", 64'd0);
        @(negedge clk);
        rst  = 1'b1;
        a    = 32'h00000003;
        b    = 32'h00000005;
        mode = 1'b1;
        @(posedge clk); #1; check("midrel_edge1", 64'd0);
        @(negedge clk);
        a    = 32'hFFFFFFFF;
        b    = 32'hFFFFFFFF;
        mode = 1'b0;
        @(posedge clk); #1; check("midrel_edge2", 64'd0);
        @(posedge clk); #1; check("midrel_first", 64'd15);
        @(posedge clk); #1; check("midrel_second", 64'hFFFFFFFE_00000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
